// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM behind a mem_read/mem_write/mem_wait handshake,
// with programmable wait states and load-reserved/store-conditional support.
module data_mem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int SIZE    = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data_w,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_atomic,
  output logic [DATA_W-1:0] mem_data_r,
  output logic              mem_wait,
  input  logic              inv_valid,
  input  logic [ADDR_W-1:0] inv_addr
);
  localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt, w_cnt_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wr, r_atomic;
  logic                r_resv_valid;
  logic [ADDR_W-1:0]   r_resv_addr;
  logic [DATA_W-1:0]   r_mem [SIZE];

  logic                w_req, w_accept, w_perform;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_wdata;
  logic                w_wr, w_atomic;
  logic                w_in_range, w_sc_ok, w_inv_hit, w_mem_we;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_rdata;

  assign w_req    = mem_read | mem_write;
  assign w_accept = (r_state == S_IDLE) & w_req & en;
  assign w_perform = en & (((r_state == S_IDLE) & w_req & (LATENCY == 0)) |
                           ((r_state == S_WAIT) & (r_cnt == 4'd0)));

  // With zero latency the access happens at the accept edge, so use the live inputs.
  assign w_addr   = (r_state == S_IDLE) ? mem_addr   : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? mem_data_w : r_wdata;
  assign w_wr     = (r_state == S_IDLE) ? mem_write  : r_wr;
  assign w_atomic = (r_state == S_IDLE) ? mem_atomic : r_atomic;

  assign w_in_range = w_addr < ADDR_W'(SIZE);
  assign w_idx      = w_addr[IDX_W-1:0];
  assign w_rdata    = w_in_range ? r_mem[w_idx] : '0;
  assign w_inv_hit  = inv_valid & (inv_addr == r_resv_addr);
  assign w_sc_ok    = r_resv_valid & (r_resv_addr == w_addr) & w_in_range &
                      ~(inv_valid & (inv_addr == w_addr));
  assign w_mem_we   = w_perform & w_wr & w_in_range & (~w_atomic | w_sc_ok) & ~rst;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    mem_wait   = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_wait = w_req;
        if (w_accept) begin
          if (LATENCY == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = 4'(LATENCY - 1);
          end
        end
      end
      S_WAIT: begin
        mem_wait = 1'b1;
        if (en) begin
          if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
          else               w_next     = S_RESP;
        end
      end
      S_RESP: begin
        if (en) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_resv_valid <= 1'b0;
      mem_data_r   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_addr   <= mem_addr;
        r_wdata  <= mem_data_w;
        r_wr     <= mem_write;
        r_atomic <= mem_atomic;
      end
      if (w_inv_hit) r_resv_valid <= 1'b0;
      // Access results take priority over a same-edge invalidate.
      if (w_perform) begin
        if (w_wr && w_atomic) begin
          r_resv_valid <= 1'b0;
          mem_data_r   <= w_sc_ok ? '0 : DATA_W'(1);
        end else if (w_wr) begin
          if (r_resv_addr == w_addr) r_resv_valid <= 1'b0;
          mem_data_r <= '0;
        end else begin
          mem_data_r <= w_rdata;
          if (w_atomic && w_in_range) begin
            r_resv_valid <= 1'b1;
            r_resv_addr  <= w_addr;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_wdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=2 instance carries most
// scenarios, a LATENCY=0 instance checks the zero-wait path.
module tb_data_mem_responder;
  logic        clk, rst, en;
  logic [31:0] mem_addr, mem_data_w, inv_addr;
  logic        mem_read, mem_write, mem_atomic, inv_valid;
  logic [31:0] mem_data_r;
  logic        mem_wait;
  logic        mem_read0, mem_write0;
  logic [31:0] mem_data_r0;
  logic        mem_wait0;
  int checks, fails;

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .SIZE(1024), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr), .mem_data_w(mem_data_w),
    .mem_read(mem_read), .mem_write(mem_write), .mem_atomic(mem_atomic),
    .mem_data_r(mem_data_r), .mem_wait(mem_wait), .inv_valid(inv_valid), .inv_addr(inv_addr));

  data_mem_responder #(.DATA_W(32), .ADDR_W(32), .SIZE(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr), .mem_data_w(mem_data_w),
    .mem_read(mem_read0), .mem_write(mem_write0), .mem_atomic(mem_atomic),
    .mem_data_r(mem_data_r0), .mem_wait(mem_wait0), .inv_valid(inv_valid), .inv_addr(inv_addr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request; k is the cycle index relative to first assertion.
  // inv_valid is pulsed in cycle inv_at, en is low in cycles en_lo..en_hi.
  task automatic do_req(input bit sel, input bit w, input bit a, input logic [31:0] addr,
                        input logic [31:0] d, input int inv_at, input int en_lo,
                        input int en_hi, output logic [31:0] rdata, output int lat);
    int k;
    bit done;
    @(posedge clk); #1;
    mem_addr = addr; mem_data_w = d; mem_atomic = a;
    if (sel) begin mem_write0 = w; mem_read0 = !w; end
    else     begin mem_write  = w; mem_read  = !w; end
    k = 0; done = 0;
    while (!done) begin
      inv_valid = (k == inv_at);
      en = !(k >= en_lo && k <= en_hi);
      @(negedge clk);
      if (!(sel ? mem_wait0 : mem_wait)) done = 1;
      else begin
        k++;
        if (k > 60) begin
          checks++; fails++;
          $display("FAIL timeout addr=%0d got=no completion required=completion", addr);
          done = 1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end
    rdata = sel ? mem_data_r0 : mem_data_r;
    lat = k;
    @(posedge clk); #1;
    mem_read = 0; mem_write = 0; mem_read0 = 0; mem_write0 = 0;
    mem_atomic = 0; inv_valid = 0; en = 1;
  endtask

  task automatic acc(input bit w, input bit a, input logic [31:0] addr, input logic [31:0] d,
                     output logic [31:0] rdata, output int lat);
    do_req(1'b0, w, a, addr, d, -1, -1, -2, rdata, lat);
  endtask

  task automatic inv_pulse(input logic [31:0] addr);
    @(posedge clk); #1; inv_valid = 1; inv_addr = addr;
    @(posedge clk); #1; inv_valid = 0;
  endtask

  task automatic test_reset;
    rst = 1;
    @(posedge clk); #1; mem_read = 1; mem_addr = 0;
    @(negedge clk);
    checks++; if (mem_wait !== 1'b1) begin fails++; $display("FAIL rst_wait_req got=%b required=1", mem_wait); end
    @(posedge clk); #1; mem_read = 0; rst = 0;
    @(negedge clk);
    checks++; if (mem_wait !== 1'b0) begin fails++; $display("FAIL rst_wait_idle got=%b required=0", mem_wait); end
    checks++; if (mem_data_r !== 32'h0) begin fails++; $display("FAIL rst_data got=%h required=0", mem_data_r); end
    checks++; if (mem_data_r0 !== 32'h0) begin fails++; $display("FAIL rst_data0 got=%h required=0", mem_data_r0); end
  endtask

  task automatic test_wait_states;
    logic [31:0] d; int l;
    acc(1, 0, 100, 32'h1, d, l);
    checks++; if (l !== 3) begin fails++; $display("FAIL wr_latency got=%0d required=3", l); end
    acc(0, 0, 100, 0, d, l);
    checks++; if (l !== 3) begin fails++; $display("FAIL rd_latency got=%0d required=3", l); end
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL rd100 got=%h required=1", d); end
    do_req(1, 1, 0, 100, 32'h1, -1, -1, -2, d, l);
    checks++; if (l !== 1) begin fails++; $display("FAIL lat0_wr_latency got=%0d required=1", l); end
    do_req(1, 0, 0, 100, 0, -1, -1, -2, d, l);
    checks++; if (l !== 1) begin fails++; $display("FAIL lat0_rd_latency got=%0d required=1", l); end
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL lat0_rd100 got=%h required=1", d); end
  endtask

  task automatic test_store_load;
    logic [31:0] d; int l;
    acc(1, 0, 0, 32'h55, d, l);
    acc(1, 0, 300, 32'h1ABCDEF0, d, l);
    acc(0, 0, 300, 0, d, l);
    checks++; if (d !== 32'h1ABCDEF0) begin fails++; $display("FAIL rd300 got=%h required=1abcdef0", d); end
    acc(1, 0, 1024, 32'hDEAD, d, l);
    checks++; if (l !== 3) begin fails++; $display("FAIL oor_wr_latency got=%0d required=3", l); end
    acc(0, 0, 1024, 0, d, l);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL oor_rd got=%h required=0", d); end
    acc(0, 0, 0, 0, d, l);
    checks++; if (d !== 32'h55) begin fails++; $display("FAIL rd0_after_oor got=%h required=55", d); end
  endtask

  task automatic test_lrsc;
    logic [31:0] d; int l;
    acc(1, 0, 200, 32'h4, d, l);
    acc(0, 1, 200, 0, d, l);
    checks++; if (d !== 32'h4) begin fails++; $display("FAIL lr200 got=%h required=4", d); end
    acc(1, 1, 200, 32'h5, d, l);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL sc_ok got=%h required=0", d); end
    acc(0, 0, 200, 0, d, l);
    checks++; if (d !== 32'h5) begin fails++; $display("FAIL rd200_after_sc got=%h required=5", d); end
    acc(1, 1, 200, 32'h6, d, l);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL sc_second got=%h required=1", d); end
    acc(0, 0, 200, 0, d, l);
    checks++; if (d !== 32'h5) begin fails++; $display("FAIL rd200_after_sc2 got=%h required=5", d); end
  endtask

  task automatic test_resv_break;
    logic [31:0] d; int l;
    acc(0, 1, 200, 0, d, l);
    inv_pulse(200);
    acc(1, 1, 200, 32'h7, d, l);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL sc_after_inv got=%h required=1", d); end
    acc(0, 0, 200, 0, d, l);
    checks++; if (d !== 32'h5) begin fails++; $display("FAIL rd200_after_inv got=%h required=5", d); end
    acc(0, 1, 200, 0, d, l);
    acc(1, 0, 200, 32'h8, d, l);
    acc(1, 1, 200, 32'h9, d, l);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL sc_after_wr got=%h required=1", d); end
    acc(0, 0, 200, 0, d, l);
    checks++; if (d !== 32'h8) begin fails++; $display("FAIL rd200_after_wr got=%h required=8", d); end
    acc(1, 0, 201, 32'h3, d, l);
    acc(0, 1, 200, 0, d, l);
    acc(1, 1, 201, 32'hA, d, l);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL sc_other_addr got=%h required=1", d); end
    acc(0, 0, 201, 0, d, l);
    checks++; if (d !== 32'h3) begin fails++; $display("FAIL rd201 got=%h required=3", d); end
    acc(0, 1, 200, 0, d, l);
    inv_pulse(201);
    acc(1, 1, 200, 32'hB, d, l);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL sc_unrelated_inv got=%h required=0", d); end
    acc(0, 0, 200, 0, d, l);
    checks++; if (d !== 32'hB) begin fails++; $display("FAIL rd200_after_sc3 got=%h required=b", d); end
  endtask

  task automatic test_inv_at_sc;
    logic [31:0] d; int l;
    acc(0, 1, 200, 0, d, l);
    inv_addr = 200;
    do_req(0, 1, 1, 200, 32'hC, 2, -1, -2, d, l);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL sc_inv_same_edge got=%h required=1", d); end
    acc(0, 0, 200, 0, d, l);
    checks++; if (d !== 32'hB) begin fails++; $display("FAIL rd200_after_edge_inv got=%h required=b", d); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d; int l;
    acc(1, 0, 50, 32'h9, d, l);
    acc(0, 1, 50, 0, d, l);
    @(posedge clk); #1; mem_write = 1; mem_addr = 50; mem_data_w = 32'h7;
    @(posedge clk); #1; rst = 1; mem_write = 0;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    checks++; if (mem_data_r !== 32'h0) begin fails++; $display("FAIL mid_rst_data got=%h required=0", mem_data_r); end
    checks++; if (mem_wait !== 1'b0) begin fails++; $display("FAIL mid_rst_idle got=%b required=0", mem_wait); end
    acc(0, 0, 50, 0, d, l);
    checks++; if (d !== 32'h9) begin fails++; $display("FAIL rd50_after_rst got=%h required=9", d); end
    acc(1, 1, 50, 32'h8, d, l);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL sc_after_rst got=%h required=1", d); end
    acc(1, 0, 50, 32'h7, d, l);
    checks++; if (l !== 3) begin fails++; $display("FAIL reissue_latency got=%0d required=3", l); end
    acc(0, 0, 50, 0, d, l);
    checks++; if (d !== 32'h7) begin fails++; $display("FAIL rd50_reissue got=%h required=7", d); end
  endtask

  task automatic test_clock_enable;
    logic [31:0] d; int l;
    do_req(0, 1, 0, 400, 32'h77, -1, 1, 3, d, l);
    checks++; if (l !== 6) begin fails++; $display("FAIL en_stall_latency got=%0d required=6", l); end
    acc(0, 0, 400, 0, d, l);
    checks++; if (d !== 32'h77) begin fails++; $display("FAIL rd400 got=%h required=77", d); end
  endtask

  initial begin
    checks = 0; fails = 0;
    rst = 1; en = 1; mem_addr = 0; mem_data_w = 0; inv_addr = 0;
    mem_read = 0; mem_write = 0; mem_atomic = 0; inv_valid = 0;
    mem_read0 = 0; mem_write0 = 0;
    test_reset;
    test_wait_states;
    test_store_load;
    test_lrsc;
    test_resv_break;
    test_inv_at_sc;
    test_reset_mid;
    test_clock_enable;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
